// File: rtl/pipe_latch_ctrl.sv
// Pipeline latch sequencer for the DLX five-stage pipe: generates every latch enable and
// bubble strobe from load-use hazards, taken branches, multi-cycle multiplies and debug halt.
module pipe_latch_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 3,
   parameter int STALL_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  id_branch_taken,
   input  logic                  id_mul_start,
   input  logic                  halt_req,
   input  logic                  resume,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  mem_wb_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic [1:0]            ctrl_state,
   output logic [STALL_W-1:0]    stall_count
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MUL_WAIT = 2'b01,
      HALT     = 2'b10,
      ILLEGAL  = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
   logic               halt_pend_q, halt_pend_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               hz;

   // r0 is hardwired zero, so a load targeting it can never create a real dependency
   assign hz = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      if (!reset) begin
         case (state_q)
            RUN: begin
               pc_en     = 1'b1;
               if_id_en  = 1'b1;
               id_ex_en  = 1'b1;
               ex_mem_en = 1'b1;
               mem_wb_en = 1'b1;
               if (hz) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end else if (id_branch_taken) begin
                  if_id_flush = 1'b1;
               end
            end
            MUL_WAIT: begin
               ex_mem_en    = 1'b1;
               mem_wb_en    = 1'b1;
               ex_mem_flush = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Next-state logic; a halt request during a multiply is remembered until the multiply drains
   always_comb begin
      state_d     = state_q;
      mul_cnt_d   = mul_cnt_q;
      halt_pend_d = halt_pend_q;
      stall_d     = stall_q;
      if (!pc_en && (state_q != HALT) && (stall_q != '1))
         stall_d = stall_q + 1'b1;
      case (state_q)
         RUN: begin
            if (halt_req)
               state_d = HALT;
            else if (id_mul_start && !hz && !id_branch_taken) begin
               state_d   = MUL_WAIT;
               mul_cnt_d = CNT_W'(MUL_CYCLES - 2);
            end
         end
         MUL_WAIT: begin
            if (halt_req)
               halt_pend_d = 1'b1;
            if (mul_cnt_q != '0)
               mul_cnt_d = mul_cnt_q - 1'b1;
            else begin
               state_d     = (halt_pend_q || halt_req) ? HALT : RUN;
               halt_pend_d = 1'b0;
            end
         end
         HALT: begin
            if (resume)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         mul_cnt_q   <= '0;
         halt_pend_q <= 1'b0;
         stall_q     <= '0;
      end else begin
         state_q     <= state_d;
         mul_cnt_q   <= mul_cnt_d;
         halt_pend_q <= halt_pend_d;
         stall_q     <= stall_d;
      end
   end

   assign ctrl_state  = state_q;
   assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_latch_ctrl.sv
// Self-checking bench for pipe_latch_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the sequencer rules.
module tb_pipe_latch_ctrl;

   localparam int MUL_CYCLES = 4;
   localparam int STALL_MAX  = 65535;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic id_branch_taken = 1'b0, id_mul_start = 1'b0, halt_req = 1'b0, resume = 1'b0;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_count;
   logic [7:0]  outVec;

   int compared = 0;
   int mismatched = 0;

   // Model: mode 0 run, 1 multiply wait, 2 halted; waitLeft counts remaining wait cycles
   int mMode = 0;
   int mWaitLeft = 0;
   bit mPend = 0;
   int mStall = 0;

   pipe_latch_ctrl #(.REG_ADDR_W(5), .MUL_CYCLES(MUL_CYCLES), .CNT_W(3), .STALL_W(16)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .id_branch_taken(id_branch_taken), .id_mul_start(id_mul_start),
      .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .if_id_en(if_id_en),
      .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .ctrl_state(ctrl_state), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   assign outVec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush};

   function automatic bit modelHazard();
      bit rsHit, rtHit;
      rsHit = id_uses_rs && (id_rs == ex_rd);
      rtHit = id_uses_rt && (id_rt == ex_rd);
      return ex_mem_read && (ex_rd != 5'd0) && (rsHit || rtHit);
   endfunction

   // Bit order: pc, if_id, id_ex, ex_mem, mem_wb enables, then if_id, id_ex, ex_mem flushes
   function automatic logic [7:0] expOut();
      if (reset) return 8'b00000_000;
      if (mMode == 1) return 8'b00011_001;
      if (mMode == 2) return 8'b00000_000;
      if (modelHazard()) return 8'b00111_010;
      if (id_branch_taken) return 8'b11111_100;
      return 8'b11111_000;
   endfunction

   function automatic logic [1:0] expState();
      return 2'(mMode);
   endfunction

   function automatic logic [15:0] expStall();
      return 16'(mStall);
   endfunction

   task automatic modelStep();
      logic [7:0] o;
      o = expOut();
      if (reset) begin
         mMode = 0; mWaitLeft = 0; mPend = 0; mStall = 0;
         return;
      end
      if (o[7] == 1'b0 && mMode != 2 && mStall < STALL_MAX) mStall++;
      case (mMode)
         0: begin
            if (halt_req) mMode = 2;
            else if (id_mul_start && !modelHazard() && !id_branch_taken) begin
               mMode = 1;
               mWaitLeft = MUL_CYCLES - 1;
            end
         end
         1: begin
            if (halt_req) mPend = 1;
            mWaitLeft--;
            if (mWaitLeft == 0) begin
               mMode = (mPend || halt_req) ? 2 : 0;
               mPend = 0;
            end
         end
         default: if (resume) mMode = 0;
      endcase
   endtask

   task automatic advance();
      @(posedge clk);
      modelStep();
   endtask

   task automatic applyIdle();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
      id_branch_taken = 0; id_mul_start = 0; halt_req = 0; resume = 0;
   endtask

   task automatic test_reset();
      applyIdle();
      @(posedge clk);
      modelStep();
      @(negedge clk); #1;
      compared++;
      if (outVec !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_outputs got %b want %b", outVec, 8'h00); end
      compared++;
      if (ctrl_state !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_state got %b want 00", ctrl_state); end
      compared++;
      if (stall_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_stall got %0d want 0", stall_count); end
      reset = 0;
      #1;
      compared++;
      if (outVec !== 8'b11111_000) begin mismatched++; $display("[TB] FAIL post_reset_run got %b want 11111000", outVec); end
      advance();
   endtask

   task automatic test_load_use();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
      #1;
      compared++;
      if (outVec !== 8'b00111_010) begin mismatched++; $display("[TB] FAIL load_use_stall got %b want 00111010", outVec); end
      advance();
      @(negedge clk);
      applyIdle();
      #1;
      compared++;
      if (outVec !== 8'b11111_000) begin mismatched++; $display("[TB] FAIL load_use_release got %b want 11111000", outVec); end
      compared++;
      if (stall_count !== 16'd1) begin mismatched++; $display("[TB] FAIL load_use_count got %0d want 1", stall_count); end
      advance();
   endtask

   task automatic test_r0_unused();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
      #1;
      compared++;
      if (outVec !== 8'b11111_000) begin mismatched++; $display("[TB] FAIL r0_no_stall got %b want 11111000", outVec); end
      advance();
      @(negedge clk);
      ex_rd = 7; id_rt = 7; id_uses_rt = 0; id_rs = 3; id_uses_rs = 1;
      #1;
      compared++;
      if (outVec !== 8'b11111_000) begin mismatched++; $display("[TB] FAIL unused_rt_no_stall got %b want 11111000", outVec); end
      advance();
      @(negedge clk);
      applyIdle();
      #1;
      compared++;
      if (stall_count !== 16'd1) begin mismatched++; $display("[TB] FAIL r0_count got %0d want 1", stall_count); end
   endtask

   task automatic test_branch_hazard();
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1; id_branch_taken = 1;
      #1;
      compared++;
      if (outVec !== 8'b00111_010) begin mismatched++; $display("[TB] FAIL branch_vs_hazard got %b want 00111010", outVec); end
      advance();
      @(negedge clk);
      ex_mem_read = 0;
      #1;
      compared++;
      if (outVec !== 8'b11111_100) begin mismatched++; $display("[TB] FAIL branch_flush got %b want 11111100", outVec); end
      advance();
      @(negedge clk);
      applyIdle();
   endtask

   task automatic test_multiply();
      int s0;
      s0 = mStall;
      id_mul_start = 1;
      #1;
      compared++;
      if (outVec !== 8'b11111_000) begin mismatched++; $display("[TB] FAIL mul_issue got %b want 11111000", outVec); end
      advance();
      @(negedge clk);
      applyIdle();
      for (int c = 0; c < MUL_CYCLES - 1; c++) begin
         #1;
         compared++;
         if (ctrl_state !== 2'b01 || outVec !== 8'b00011_001) begin
            mismatched++;
            $display("[TB] FAIL mul_wait_%0d got state %b out %b want 01 00011001", c, ctrl_state, outVec);
         end
         advance();
         @(negedge clk);
      end
      #1;
      compared++;
      if (ctrl_state !== 2'b00) begin mismatched++; $display("[TB] FAIL mul_done_state got %b want 00", ctrl_state); end
      compared++;
      if (stall_count !== 16'(s0 + 3)) begin mismatched++; $display("[TB] FAIL mul_count got %0d want %0d", stall_count, s0 + 3); end
   endtask

   task automatic test_halt_during_mul();
      int s0;
      s0 = mStall;
      @(negedge clk);
      id_mul_start = 1;
      advance();
      for (int c = 0; c < MUL_CYCLES - 1; c++) begin
         @(negedge clk);
         applyIdle();
         halt_req = (c == 1);
         advance();
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         applyIdle();
         #1;
         compared++;
         if (ctrl_state !== 2'b10 || outVec !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL halt_hold_%0d got state %b out %b want 10 00000000", c, ctrl_state, outVec);
         end
         advance();
      end
      @(negedge clk);
      resume = 1;
      advance();
      @(negedge clk);
      applyIdle();
      #1;
      compared++;
      if (ctrl_state !== 2'b00) begin mismatched++; $display("[TB] FAIL resume_state got %b want 00", ctrl_state); end
      compared++;
      if (stall_count !== 16'(s0 + 3)) begin mismatched++; $display("[TB] FAIL halt_not_counted got %0d want %0d", stall_count, s0 + 3); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      id_mul_start = 1;
      advance();
      @(negedge clk);
      applyIdle();
      advance();
      #2;
      reset = 1;
      #1;
      compared++;
      if (outVec !== 8'h00 || ctrl_state !== 2'b00 || stall_count !== 16'd0) begin
         mismatched++;
         $display("[TB] FAIL async_reset got out %b state %b stall %0d want 0 00 0", outVec, ctrl_state, stall_count);
      end
      advance();
      @(negedge clk);
      reset = 0;
      for (int c = 0; c < 2; c++) begin
         #1;
         compared++;
         if (outVec !== 8'b11111_000 || ctrl_state !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL post_async_%0d got out %b state %b want 11111000 00", c, outVec, ctrl_state);
         end
         advance();
         @(negedge clk);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3));
         id_uses_rs = ($urandom_range(0, 1) == 0);
         id_uses_rt = ($urandom_range(0, 1) == 0);
         ex_mem_read = ($urandom_range(0, 2) == 0);
         id_branch_taken = ($urandom_range(0, 4) == 0);
         id_mul_start = ($urandom_range(0, 5) == 0);
         halt_req = ($urandom_range(0, 19) == 0);
         resume = ($urandom_range(0, 3) == 0);
         #1;
         compared++;
         if (outVec !== expOut() || ctrl_state !== expState() || stall_count !== expStall()) begin
            mismatched++;
            $display("[TB] FAIL random_%0d got out %b state %b stall %0d want %b %b %0d",
                     c, outVec, ctrl_state, stall_count, expOut(), expState(), expStall());
         end
         advance();
      end
      @(negedge clk);
      applyIdle();
   endtask

   task automatic test_saturation();
      reset = 1;
      advance();
      @(negedge clk);
      reset = 0;
      ex_mem_read = 1; ex_rd = 4; id_rs = 4; id_uses_rs = 1;
      for (int c = 0; c < STALL_MAX + 5; c++) advance();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         compared++;
         if (stall_count !== 16'hFFFF || stall_count !== expStall()) begin
            mismatched++;
            $display("[TB] FAIL stall_saturate_%0d got %h want ffff", c, stall_count);
         end
         advance();
      end
      @(negedge clk);
      applyIdle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_r0_unused();
      test_branch_hazard();
      test_multiply();
      test_halt_during_mul();
      test_async_reset();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
